memoria_datos_bytes: RTL and testbench
======================================

MEMORIA_DATOS_BYTES -- requirements
Module: memoria_datos_bytes

Interface
REQ-001 SHALL have parameter Ancho_Dato, default 32, data word width; only 32 is supported (4 byte lanes).
REQ-002 SHALL have parameter Ancho_Direccion, default 32, byte-address width.
REQ-003 SHALL have parameter Tamanio_Mem, default 256, depth in words; power of two, at least 4.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port escritura_habilitada, input, 1, store request this cycle.
REQ-007 SHALL have port lectura_habilitada, input, 1, load request this cycle.
REQ-008 SHALL have port direccion, input, Ancho_Direccion, byte address.
REQ-009 SHALL have port dato_escritura, input, Ancho_Dato, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port tamanio, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-011 SHALL have port sin_signo, input, 1, load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port dato_lectura, output, Ancho_Dato, registered load result.
REQ-013 SHALL have port dato_valido, output, 1, one-cycle pulse marking a load response.
REQ-014 SHALL have port error_acceso, output, 1, one-cycle pulse marking a faulted request.
REQ-015 SHALL have port listo, output, 1, high once initialisation sweep completes.

Function
REQ-016 SHALL decode word index = direccion[log2(Tamanio_Mem)+1:2], byte offset = direccion[1:0].
REQ-017 SHALL implement FSM states INIT and IDLE; INIT entered on reset, IDLE after sweep; no other transitions.
REQ-018 In INIT SHALL write zero to one word per cycle, index 0 upward, Tamanio_Mem cycles total, listo=0, then enter IDLE and set listo=1.
REQ-019 Requests while listo=0 SHALL be ignored: no memory change, no dato_valido, no error_acceso.
REQ-020 A request SHALL fault if: tamanio=11; half with offset[0]=1; word with offset!=00; direccion >= 4*Tamanio_Mem; or both enables high.
REQ-021 A faulted request SHALL leave memory and dato_lectura unchanged and pulse error_acceso=1 one cycle later, dato_valido=0.
REQ-022 A valid store SHALL update only the addressed lanes (byte: lane offset; half: lanes offset, offset+1; word: all) at the request edge; other lanes unchanged.
REQ-023 A valid store SHALL produce no response pulse.
REQ-024 A valid load SHALL have latency 1: dato_lectura updated and dato_valido=1 in the cycle after the request edge.
REQ-025 Load data SHALL be the addressed byte/half/word shifted to bit 0, extended per sin_signo; sin_signo ignored for word.
REQ-026 dato_lectura SHALL hold its last value between load responses.
REQ-027 A load issued the cycle after a store to the same word SHALL return the stored value.
REQ-028 Back-to-back requests every cycle SHALL be accepted with no stall.

Reset
REQ-029 On rst_n=0, asynchronously: dato_lectura=0, dato_valido=0, error_acceso=0, listo=0, sweep counter=0, state=INIT.
REQ-030 Reset asserted mid-sweep or mid-operation SHALL restart the full sweep after release; memory is not otherwise reset.

Verification
REQ-031 Release reset, idle -> listo low exactly Tamanio_Mem cycles (256), then high; load of 0x3FC returns 0x00000000.
REQ-032 Word store 0xDEADBEEF @0x0, 0xCAFEBABE @0x4, 0xABCDEF01 @0x3FC; word loads -> same values, dato_valido one cycle after each request.
REQ-033 Byte store 0x80 @0x11 into word 0x12345678 @0x10 -> word load 0x12348078; signed byte load @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half @0x12 -> 0x00001234.
REQ-034 Word load @0x2, half store @0x1, tamanio=11, address 0x400, both enables high -> each pulses error_acceso, memory unchanged, dato_lectura unchanged.
REQ-035 Request during INIT -> no response, memory unaffected; rst_n pulsed at sweep cycle 100 -> listo rises 256 cycles after release.

Source files
------------

// File: rtl/memoria_datos_bytes.sv
// Byte-addressable data memory with byte/half/word loads and stores.
// After reset an initialisation sweep writes zero to every word, one word per
// cycle. Requests are ignored until that sweep finishes and listo rises.
// Loads answer one cycle after the request edge. Faulted requests (misaligned,
// reserved size, out of range, or store+load at once) pulse error_acceso.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   escritura_habilitada  store request this cycle
//   lectura_habilitada    load request this cycle
//   direccion             byte address
//   dato_escritura        store data, right-aligned
//   tamanio               00 byte, 01 half, 10 word, 11 reserved
//   sin_signo             load zero-extends when 1, sign-extends when 0
//   dato_lectura          registered load result, held between loads
//   dato_valido           one-cycle load response pulse
//   error_acceso          one-cycle fault pulse
//   listo                 high once the initialisation sweep is done
module memoria_datos_bytes #(
    parameter int unsigned Ancho_Dato      = 32,
    parameter int unsigned Ancho_Direccion = 32,
    parameter int unsigned Tamanio_Mem     = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       escritura_habilitada,
    input  logic                       lectura_habilitada,
    input  logic [Ancho_Direccion-1:0] direccion,
    input  logic [Ancho_Dato-1:0]      dato_escritura,
    input  logic [1:0]                 tamanio,
    input  logic                       sin_signo,
    output logic [Ancho_Dato-1:0]      dato_lectura,
    output logic                       dato_valido,
    output logic                       error_acceso,
    output logic                       listo
);

    localparam int unsigned IDX_W = $clog2(Tamanio_Mem);
    localparam int unsigned LANES = Ancho_Dato / 8;

    localparam logic [1:0] TAM_BYTE = 2'b00;
    localparam logic [1:0] TAM_HALF = 2'b01;
    localparam logic [1:0] TAM_WORD = 2'b10;
    localparam logic [1:0] TAM_RSVD = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [Ancho_Dato-1:0]  dato_lectura_q, dato_lectura_d;
    logic                   dato_valido_q, dato_valido_d;
    logic                   error_acceso_q, error_acceso_d;
    logic                   listo_q, listo_d;

    logic [Ancho_Dato-1:0]  mem_q [Tamanio_Mem];

    // Memory write port, shared by the sweep and by stores
    logic                   mem_we;
    logic [IDX_W-1:0]       mem_idx;
    logic [LANES-1:0]       mem_be;
    logic [Ancho_Dato-1:0]  mem_wdata;

    // Address decode
    logic [IDX_W-1:0]       indice;
    logic [1:0]             offset;
    logic [4:0]             desplaz;
    logic                   fuera_rango;
    logic                   peticion;
    logic                   falla;

    // Store lane enables/data and load result
    logic [LANES-1:0]       be_c;
    logic [Ancho_Dato-1:0]  wdata_c;
    logic [Ancho_Dato-1:0]  palabra;
    logic [Ancho_Dato-1:0]  desplazada;
    logic [Ancho_Dato-1:0]  carga_c;

    assign indice      = direccion[IDX_W+1:2];
    assign offset      = direccion[1:0];
    assign desplaz     = {offset, 3'b000};
    // Any address bit above the word index means the address is past the end
    assign fuera_rango = |direccion[Ancho_Direccion-1:IDX_W+2];
    assign peticion    = escritura_habilitada | lectura_habilitada;

    // Fault detection
    always_comb begin
        falla = 1'b0;
        if (peticion) begin
            falla = (tamanio == TAM_RSVD)
                  | ((tamanio == TAM_HALF) & offset[0])
                  | ((tamanio == TAM_WORD) & (offset != 2'b00))
                  | fuera_rango
                  | (escritura_habilitada & lectura_habilitada);
        end
    end

    // Store lane selection: data moved up to the addressed lanes
    always_comb begin
        wdata_c = dato_escritura << desplaz;
        case (tamanio)
            TAM_BYTE: be_c = LANES'(1) << offset;
            TAM_HALF: be_c = LANES'(3) << offset;
            default:  be_c = '1;
        endcase
    end

    // Load extraction: addressed bytes moved down to bit 0, then extended
    always_comb begin
        palabra    = mem_q[indice];
        desplazada = palabra >> desplaz;
        case (tamanio)
            TAM_BYTE: carga_c = {{(Ancho_Dato-8){~sin_signo & desplazada[7]}},
                                 desplazada[7:0]};
            TAM_HALF: carga_c = {{(Ancho_Dato-16){~sin_signo & desplazada[15]}},
                                 desplazada[15:0]};
            default:  carga_c = palabra;
        endcase
    end

    // Next-state and response logic
    always_comb begin
        estado_d       = estado_q;
        cnt_d          = cnt_q;
        dato_lectura_d = dato_lectura_q;
        dato_valido_d  = 1'b0;
        error_acceso_d = 1'b0;
        listo_d        = listo_q;
        mem_we         = 1'b0;
        mem_idx        = indice;
        mem_be         = '0;
        mem_wdata      = '0;

        case (estado_q)
            ST_INIT: begin
                // Zero one word per cycle; requests are dropped meanwhile
                mem_we    = 1'b1;
                mem_idx   = cnt_q;
                mem_be    = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(Tamanio_Mem - 1)) begin
                    estado_d = ST_IDLE;
                    listo_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_IDLE: begin
                if (falla) begin
                    error_acceso_d = 1'b1;
                end else if (escritura_habilitada) begin
                    mem_we    = 1'b1;
                    mem_be    = be_c;
                    mem_wdata = wdata_c;
                end else if (lectura_habilitada) begin
                    dato_valido_d  = 1'b1;
                    dato_lectura_d = carga_c;
                end
            end
            default: begin
                estado_d = ST_INIT;
            end
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q       <= ST_INIT;
            cnt_q          <= '0;
            dato_lectura_q <= '0;
            dato_valido_q  <= 1'b0;
            error_acceso_q <= 1'b0;
            listo_q        <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cnt_q          <= cnt_d;
            dato_lectura_q <= dato_lectura_d;
            dato_valido_q  <= dato_valido_d;
            error_acceso_q <= error_acceso_d;
            listo_q        <= listo_d;
        end
    end

    // Storage array; cleared only by the sweep, never by reset directly
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dato_lectura = dato_lectura_q;
    assign dato_valido  = dato_valido_q;
    assign error_acceso = error_acceso_q;
    assign listo        = listo_q;

endmodule

// File: tb/tb_memoria_datos_bytes.sv
// Scoreboard bench for memoria_datos_bytes: stimulus pushes expected
// responses computed from a byte-array reference model; a negedge monitor
// pops and compares whenever the DUT pulses dato_valido or error_acceso.
module tb_memoria_datos_bytes;

    localparam int unsigned MEM   = 256;
    localparam int unsigned BYTES = 4 * MEM;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        escritura_habilitada;
    logic        lectura_habilitada;
    logic [31:0] direccion;
    logic [31:0] dato_escritura;
    logic [1:0]  tamanio;
    logic        sin_signo;
    logic [31:0] dato_lectura;
    logic        dato_valido;
    logic        error_acceso;
    logic        listo;

    always #5 clk = ~clk;

    memoria_datos_bytes #(
        .Ancho_Dato      (32),
        .Ancho_Direccion (32),
        .Tamanio_Mem     (MEM)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .escritura_habilitada (escritura_habilitada),
        .lectura_habilitada   (lectura_habilitada),
        .direccion            (direccion),
        .dato_escritura       (dato_escritura),
        .tamanio              (tamanio),
        .sin_signo            (sin_signo),
        .dato_lectura         (dato_lectura),
        .dato_valido          (dato_valido),
        .error_acceso         (error_acceso),
        .listo                (listo)
    );

    typedef struct {
        bit          es_error;
        logic [31:0] dato;
        int          ciclo;
    } resp_t;

    resp_t       cola[$];
    resp_t       e_mon;
    logic [7:0]  modelo [BYTES];
    logic [31:0] ultimo;
    bit          modelo_listo;
    int          ciclo      = 0;
    int          comparados = 0;
    int          fallos     = 0;

    always @(posedge clk) ciclo++;

    task automatic chk(input string nombre, input logic [31:0] act,
                       input logic [31:0] esp);
        comparados++;
        if (act !== esp) begin
            fallos++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nombre, act, esp, ciclo);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dato_valido === 1'b1 || error_acceso === 1'b1) begin
                if (cola.size() == 0) begin
                    comparados++;
                    fallos++;
                    $display("FAIL unexpected_resp: got valid=%b err=%b data=%h expected no response (cycle %0d)",
                             dato_valido, error_acceso, dato_lectura, ciclo);
                end else begin
                    e_mon = cola.pop_front();
                    chk("resp_kind", 32'({dato_valido, error_acceso}),
                        e_mon.es_error ? 32'd1 : 32'd2);
                    chk("resp_data", dato_lectura, e_mon.dato);
                    chk("resp_cycle", 32'(ciclo), 32'(e_mon.ciclo));
                end
            end else if (cola.size() > 0 && cola[0].ciclo <= ciclo) begin
                e_mon = cola.pop_front();
                comparados++;
                fallos++;
                $display("FAIL missing_resp: got no pulse expected %s data %h (cycle %0d)",
                         e_mon.es_error ? "error" : "load", e_mon.dato, ciclo);
            end
        end
    end

    task automatic limpiar_modelo();
        for (int i = 0; i < int'(BYTES); i++) modelo[i] = 8'h00;
        ultimo = 32'h0;
    endtask

    // Drive one request for one cycle; update the model and push expectations
    task automatic emitir(input bit we, input bit re, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input bit uns);
        int          n;
        bit          f;
        logic [31:0] v;
        resp_t       r;
        escritura_habilitada = we;
        lectura_habilitada   = re;
        direccion            = a;
        dato_escritura       = wd;
        tamanio              = sz;
        sin_signo            = uns;
        if (modelo_listo && (we || re)) begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            f = (sz == 2'd3) || ((a % n) != 0) || (a >= BYTES) || (we && re);
            if (f) begin
                r.es_error = 1'b1;
                r.dato     = ultimo;
                r.ciclo    = ciclo + 1;
                cola.push_back(r);
            end else if (we) begin
                for (int k = 0; k < n; k++) modelo[a + k] = wd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v = v | (32'(modelo[a + k]) << (8 * k));
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                ultimo     = v;
                r.es_error = 1'b0;
                r.dato     = v;
                r.ciclo    = ciclo + 1;
                cola.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic inactivo(input int ciclos);
        escritura_habilitada = 1'b0;
        lectura_habilitada   = 1'b0;
        repeat (ciclos) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic emitir_aleatorio();
        int          op;
        logic [1:0]  sz;
        logic [31:0] a;
        op = int'($urandom_range(0, 10));
        sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 1100));
        if ($urandom_range(0, 9) < 8) a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
        if (op <= 4)      emitir(1'b0, 1'b1, a, 32'h0, sz, 1'($urandom_range(0, 1)));
        else if (op <= 8) emitir(1'b1, 1'b0, a, $urandom, sz, 1'b0);
        else if (op == 9) emitir(1'b1, 1'b1, a, $urandom, sz, 1'b0);
        else              emitir(1'b0, 1'b0, a, $urandom, sz, 1'b0);
    endtask

    // Count cycles until listo while throwing random requests at the sweep
    task automatic esperar_listo();
        int n;
        n = 0;
        while (listo !== 1'b1 && n < 400) begin
            emitir_aleatorio();
            n++;
        end
        escritura_habilitada = 1'b0;
        lectura_habilitada   = 1'b0;
        chk("init_cycles", 32'(n), 32'(MEM));
        modelo_listo = 1'b1;
    endtask

    task automatic chk_reset(input string etiqueta);
        chk({etiqueta, "_dato"},  dato_lectura, 32'h0);
        chk({etiqueta, "_valid"}, 32'(dato_valido), 32'h0);
        chk({etiqueta, "_err"},   32'(error_acceso), 32'h0);
        chk({etiqueta, "_listo"}, 32'(listo), 32'h0);
    endtask

    initial begin
        rst_n                = 1'b0;
        escritura_habilitada = 1'b0;
        lectura_habilitada   = 1'b0;
        direccion            = 32'h0;
        dato_escritura       = 32'h0;
        tamanio              = 2'd0;
        sin_signo            = 1'b0;
        modelo_listo         = 1'b0;
        limpiar_modelo();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        esperar_listo();

        // Swept memory reads back zero, including the last word
        emitir(1'b0, 1'b1, 32'h3FC, 32'h0, 2'd2, 1'b0);

        // Word stores and loads, back-to-back
        emitir(1'b1, 1'b0, 32'h000, 32'hDEADBEEF, 2'd2, 1'b0);
        emitir(1'b1, 1'b0, 32'h004, 32'hCAFEBABE, 2'd2, 1'b0);
        emitir(1'b1, 1'b0, 32'h3FC, 32'hABCDEF01, 2'd2, 1'b0);
        emitir(1'b0, 1'b1, 32'h000, 32'h0, 2'd2, 1'b0);
        emitir(1'b0, 1'b1, 32'h004, 32'h0, 2'd2, 1'b0);
        emitir(1'b0, 1'b1, 32'h3FC, 32'h0, 2'd2, 1'b1);

        // Byte merge and sign/zero extension
        emitir(1'b1, 1'b0, 32'h010, 32'h12345678, 2'd2, 1'b0);
        emitir(1'b1, 1'b0, 32'h011, 32'hFFFFFF80, 2'd0, 1'b0);
        emitir(1'b0, 1'b1, 32'h010, 32'h0, 2'd2, 1'b0);
        emitir(1'b0, 1'b1, 32'h011, 32'h0, 2'd0, 1'b0);
        emitir(1'b0, 1'b1, 32'h011, 32'h0, 2'd0, 1'b1);
        emitir(1'b0, 1'b1, 32'h012, 32'h0, 2'd1, 1'b0);
        emitir(1'b0, 1'b1, 32'h010, 32'h0, 2'd1, 1'b0);

        // Faults: memory and dato_lectura stay put
        emitir(1'b0, 1'b1, 32'h002, 32'h0, 2'd2, 1'b0);
        emitir(1'b1, 1'b0, 32'h001, 32'h0000FFFF, 2'd1, 1'b0);
        emitir(1'b0, 1'b1, 32'h000, 32'h0, 2'd3, 1'b0);
        emitir(1'b0, 1'b1, 32'h400, 32'h0, 2'd2, 1'b0);
        emitir(1'b1, 1'b1, 32'h000, 32'h11111111, 2'd2, 1'b0);
        inactivo(2);
        emitir(1'b0, 1'b1, 32'h000, 32'h0, 2'd2, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) emitir_aleatorio();
        inactivo(3);

        // Reset in the middle of a sweep restarts it from the beginning
        emitir(1'b1, 1'b0, 32'h020, 32'h55AA55AA, 2'd2, 1'b0);
        inactivo(2);
        rst_n = 1'b0;
        #1;
        chk_reset("reset_op");
        modelo_listo = 1'b0;
        limpiar_modelo();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        inactivo(100);
        rst_n = 1'b0;
        #1;
        chk_reset("reset_sweep");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        esperar_listo();
        emitir(1'b0, 1'b1, 32'h020, 32'h0, 2'd2, 1'b0);
        emitir(1'b0, 1'b1, 32'h3FC, 32'h0, 2'd2, 1'b0);
        for (int i = 0; i < 200; i++) emitir_aleatorio();
        inactivo(3);

        chk("queue_empty", 32'(cola.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, fallos);
        $finish;
    end

endmodule
